fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control unit.
- Holds the program counter and the instruction register, and sequences RAM reads of the next instruction.
- Drives the 16-bit instr word the control unit decodes.
- Obeys the control unit's instr_enable, pc_enable, pcin and ram_addr_sel strobes, and muxes the shared RAM address between PC and data address.

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly upstream of the control unit. It
// owns the program counter and the instruction register, sequences the RAM
// read of the next instruction word, and shares the single RAM address port
// with the datapath's data accesses.
//
// Parameters
//   DATA_W    width of PC, instruction, bus and RAM address/data
//   RAM_LAT   RAM read latency in clocks (>= 1), address to ram_rdata valid
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   instr_enable  in   fetch request from the control unit
//   pc_enable     in   PC <= PC + 1
//   pcin          in   PC <= bus_in (wins over pc_enable)
//   bus_in        in   CPU data bus, PC load source
//   ram_addr_sel  in   0: RAM address from PC, 1: from data_addr
//   data_addr     in   data-access address from the datapath
//   ram_rdata     in   RAM read data
//   ram_addr      out  RAM address (fetch address while a fetch is in flight)
//   pc            out  current PC
//   instr         out  instruction register
//   instr_valid   out  one-cycle pulse: instr was updated at the last edge
//   busy          out  fetch in progress
//
// Build option
//   FETCH_AUTOINC_EN  when defined, the PC advances by one at the edge that
//                     captures an instruction. pcin at that edge still wins,
//                     and a simultaneous pc_enable does not add a second step.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                 DATA_W   = 16,
  parameter int                 RAM_LAT  = 1,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_enable,
  input  logic              pc_enable,
  input  logic              pcin,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ram_addr_sel,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy
);

  // A one-bit counter is kept even for RAM_LAT == 1 so the port never
  // collapses to zero width; it is simply always loaded with zero then.
  localparam int               CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e            state_q,       state_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic [DATA_W-1:0] fetch_addr_q,  fetch_addr_d;
  logic [DATA_W-1:0] instr_q,       instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] pc_q,          pc_d;

  logic              capture;
  logic              pc_step;
  logic [DATA_W-1:0] pc_inc;

  // Capture happens at the edge that ends the last WAIT cycle.
  assign capture = (state_q == S_WAIT) && (cnt_q == '0);

  // Natural modulo-2^DATA_W wrap from the fixed-width add.
  assign pc_inc = pc_q + DATA_W'(1);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_addr_d  = fetch_addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (instr_enable) begin
          // Latch the PC as it stands before any PC update at this edge, so
          // later PC activity cannot move the in-flight fetch.
          fetch_addr_d = pc_q;
          cnt_d        = CNT_INIT;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // instr_enable is deliberately not looked at here: requests that
        // arrive while busy are dropped, not queued.
        if (capture) begin
          instr_d       = ram_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC next state
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef FETCH_AUTOINC_EN
    // OR rather than add: pc_enable coinciding with capture is still one step.
    pc_step = pc_enable | capture;
`else
    pc_step = pc_enable;
`endif
    pc_d = pc_q;
    if (pcin) begin
      pc_d = bus_in;
    end else if (pc_step) begin
      pc_d = pc_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      fetch_addr_q  <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_addr_q  <= fetch_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (state_q == S_WAIT);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  // The fetch owns the RAM port for its whole duration; data accesses only
  // get through while idle.
  always_comb begin
    if (busy) begin
      ram_addr = fetch_addr_q;
    end else if (ram_addr_sel) begin
      ram_addr = data_addr;
    end else begin
      ram_addr = pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Two fetch_unit instances share one clock and one small RAM image:
//   index 0: RAM_LAT = 1
//   index 1: RAM_LAT = 3
// Expected instruction words are queued when a fetch is requested and
// retired whenever the matching instance pulses instr_valid.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_AUTOINC_EN
  localparam logic [15:0] AUTO_INC = 16'd1;
`else
  localparam logic [15:0] AUTO_INC = 16'd0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        instr_enable [2];
  logic        pc_enable    [2];
  logic        pcin         [2];
  logic [15:0] bus_in       [2];
  logic        ram_addr_sel [2];
  logic [15:0] data_addr    [2];
  logic [15:0] ram_rdata    [2];
  logic [15:0] ram_addr     [2];
  logic [15:0] pc           [2];
  logic [15:0] instr        [2];
  logic        instr_valid  [2];
  logic        busy         [2];

  logic [15:0] mem [256];

  assign ram_rdata[0] = mem[ram_addr[0][7:0]];
  assign ram_rdata[1] = mem[ram_addr[1][7:0]];

  fetch_unit #(.DATA_W(16), .RAM_LAT(1), .RESET_PC(16'h0000)) u_lat1 (
    .clk          (clk),
    .rst          (rst[0]),
    .instr_enable (instr_enable[0]),
    .pc_enable    (pc_enable[0]),
    .pcin         (pcin[0]),
    .bus_in       (bus_in[0]),
    .ram_addr_sel (ram_addr_sel[0]),
    .data_addr    (data_addr[0]),
    .ram_rdata    (ram_rdata[0]),
    .ram_addr     (ram_addr[0]),
    .pc           (pc[0]),
    .instr        (instr[0]),
    .instr_valid  (instr_valid[0]),
    .busy         (busy[0])
  );

  fetch_unit #(.DATA_W(16), .RAM_LAT(3), .RESET_PC(16'h0000)) u_lat3 (
    .clk          (clk),
    .rst          (rst[1]),
    .instr_enable (instr_enable[1]),
    .pc_enable    (pc_enable[1]),
    .pcin         (pcin[1]),
    .bus_in       (bus_in[1]),
    .ram_addr_sel (ram_addr_sel[1]),
    .data_addr    (data_addr[1]),
    .ram_rdata    (ram_rdata[1]),
    .ram_addr     (ram_addr[1]),
    .pc           (pc[1]),
    .instr        (instr[1]),
    .instr_valid  (instr_valid[1]),
    .busy         (busy[1])
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] sbq0 [$];
  logic [15:0] sbq1 [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [15:0] v);
    if (d == 0) sbq0.push_back(v);
    else        sbq1.push_back(v);
  endtask

  task automatic sb_pop(input int d, input logic [15:0] act);
    logic [15:0] e;
    checks++;
    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
      errors++;
      $display("FAIL sb_unexpected_valid_d%0d: got instr %h with instr_valid, expected no pulse", d, act);
    end else begin
      if (d == 0) e = sbq0.pop_front();
      else        e = sbq1.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL sb_instr_d%0d: got %h expected %h", d, act, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid[0] === 1'b1) sb_pop(0, instr[0]);
    if (instr_valid[1] === 1'b1) sb_pop(1, instr[1]);
  end

  typedef struct {
    logic        pcin;
    logic        pc_en;
    logic [15:0] bus;
    logic        sel;
    logic [15:0] daddr;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
  } pc_vec_t;

  pc_vec_t vecs [7];

  logic [15:0] exp1;
  logic [15:0] exp2;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hC000;
    mem[8'h04] = 16'hA5C3;
    mem[8'h10] = 16'h1111;
    mem[8'h11] = 16'h2222;
    mem[8'h12] = 16'h3333;
    mem[8'h20] = 16'h5A5A;
    mem[8'h21] = 16'hDEAD;

    //            pcin  pc_en bus       sel   daddr     exp_pc    exp_addr
    vecs[0] = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0100, 16'h0001, 16'h0100};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0100, 16'h1234, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'h5555, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'hBEEF, 16'h1235, 16'h1235};
    vecs[6] = '{1'b1, 1'b0, 16'h0004, 1'b0, 16'h0000, 16'h0004, 16'h0004};

    for (int d = 0; d < 2; d++) begin
      rst[d]          = 1'b1;
      instr_enable[d] = 1'b0;
      pc_enable[d]    = 1'b0;
      pcin[d]         = 1'b0;
      bus_in[d]       = 16'h0000;
      ram_addr_sel[d] = 1'b0;
      data_addr[d]    = 16'h0000;
    end

    // Reset
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_pc_d%0d", d),       pc[d],                16'h0000);
      chk($sformatf("rst_instr_d%0d", d),    instr[d],             16'h0000);
      chk($sformatf("rst_valid_d%0d", d),    16'(instr_valid[d]),  16'h0000);
      chk($sformatf("rst_busy_d%0d", d),     16'(busy[d]),         16'h0000);
      chk($sformatf("rst_ram_addr_d%0d", d), ram_addr[d],          16'h0000);
      rst[d] = 1'b0;
    end

    // PC priority, wrap and address mux vectors (idle, instance 0)
    for (int i = 0; i < 7; i++) begin
      pcin[0]         = vecs[i].pcin;
      pc_enable[0]    = vecs[i].pc_en;
      bus_in[0]       = vecs[i].bus;
      ram_addr_sel[0] = vecs[i].sel;
      data_addr[0]    = vecs[i].daddr;
      tick();
      chk($sformatf("vec%0d_pc", i),       pc[0],       vecs[i].exp_pc);
      chk($sformatf("vec%0d_ram_addr", i), ram_addr[0], vecs[i].exp_addr);
    end
    pcin[0] = 1'b0; pc_enable[0] = 1'b0; ram_addr_sel[0] = 1'b0;

    // Basic fetch, RAM_LAT = 1, pc = 0x0004
    instr_enable[0] = 1'b1;
    push(0, 16'hA5C3);
    tick();
    instr_enable[0] = 1'b0;
    chk("basic_busy", 16'(busy[0]), 16'h0001);
    chk("basic_ram_addr", ram_addr[0], 16'h0004);
    ram_addr_sel[0] = 1'b1;
    data_addr[0]    = 16'h0100;
    #1;
    chk("basic_ram_addr_sel_ignored", ram_addr[0], 16'h0004);
    chk("basic_valid_early", 16'(instr_valid[0]), 16'h0000);
    tick();
    chk("basic_instr", instr[0], 16'hA5C3);
    chk("basic_valid", 16'(instr_valid[0]), 16'h0001);
    chk("basic_busy_done", 16'(busy[0]), 16'h0000);
    chk("basic_ram_addr_data", ram_addr[0], 16'h0100);
    chk("basic_pc_after", pc[0], 16'h0004 + AUTO_INC);
    tick();
    chk("basic_valid_1cyc", 16'(instr_valid[0]), 16'h0000);
    chk("basic_instr_hold", instr[0], 16'hA5C3);
    ram_addr_sel[0] = 1'b0;

    // Latency, ignored request, PC moving under an in-flight fetch (RAM_LAT = 3)
    pcin[1] = 1'b1; bus_in[1] = 16'h0020;
    tick();
    pcin[1] = 1'b0;
    chk("lat_pc_load", pc[1], 16'h0020);
    instr_enable[1] = 1'b1;
    push(1, 16'h5A5A);
    tick();                                   // edge N
    chk("lat_busy_n", 16'(busy[1]), 16'h0001);
    chk("lat_addr_n", ram_addr[1], 16'h0020);
    pc_enable[1]    = 1'b1;
    ram_addr_sel[1] = 1'b1;
    data_addr[1]    = 16'h0100;
    tick();                                   // edge N+1, request repeated
    instr_enable[1] = 1'b0;
    pc_enable[1]    = 1'b0;
    chk("lat_addr_n1", ram_addr[1], 16'h0020);
    chk("lat_pc_n1", pc[1], 16'h0021);
    chk("lat_valid_n1", 16'(instr_valid[1]), 16'h0000);
    tick();                                   // edge N+2
    chk("lat_busy_n2", 16'(busy[1]), 16'h0001);
    chk("lat_valid_n2", 16'(instr_valid[1]), 16'h0000);
    chk("lat_instr_n2", instr[1], 16'h0000);
    tick();                                   // edge N+3
    chk("lat_instr_n3", instr[1], 16'h5A5A);
    chk("lat_valid_n3", 16'(instr_valid[1]), 16'h0001);
    chk("lat_busy_n3", 16'(busy[1]), 16'h0000);
    chk("lat_addr_n3", ram_addr[1], 16'h0100);
    chk("lat_pc_n3", pc[1], 16'h0021 + AUTO_INC);
    tick();
    chk("lat_valid_n4", 16'(instr_valid[1]), 16'h0000);
    chk("lat_busy_n4", 16'(busy[1]), 16'h0000);
    ram_addr_sel[1] = 1'b0;

    // Reset during the second WAIT cycle (no scoreboard entry: no pulse allowed)
    instr_enable[1] = 1'b1;
    tick();
    instr_enable[1] = 1'b0;
    tick();
    chk("rmid_busy_before", 16'(busy[1]), 16'h0001);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("rmid_busy", 16'(busy[1]), 16'h0000);
    chk("rmid_valid", 16'(instr_valid[1]), 16'h0000);
    chk("rmid_instr", instr[1], 16'h0000);
    chk("rmid_pc", pc[1], 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rmid_after%0d_valid", k), 16'(instr_valid[1]), 16'h0000);
      chk($sformatf("rmid_after%0d_instr", k), instr[1], 16'h0000);
    end

    // Capture-edge PC behaviour and back-to-back fetch (RAM_LAT = 1)
    pcin[0] = 1'b1; bus_in[0] = 16'h0010;
    tick();
    pcin[0] = 1'b0;
    instr_enable[0] = 1'b1;
    push(0, 16'h1111);
    tick();
    instr_enable[0] = 1'b0;
    tick();                                   // capture
    exp1 = 16'h0010 + AUTO_INC;
    chk("ainc_instr1", instr[0], 16'h1111);
    chk("ainc_pc1", pc[0], exp1);
    instr_enable[0] = 1'b1;                   // issued in the instr_valid cycle
    push(0, mem[exp1[7:0]]);
    tick();
    instr_enable[0] = 1'b0;
    chk("b2b_busy", 16'(busy[0]), 16'h0001);
    chk("b2b_addr", ram_addr[0], exp1);
    pc_enable[0] = 1'b1;
    tick();                                   // capture with pc_enable
    pc_enable[0] = 1'b0;
    exp2 = exp1 + 16'h0001;
    chk("ainc_instr2", instr[0], mem[exp1[7:0]]);
    chk("ainc_pc2", pc[0], exp2);
    instr_enable[0] = 1'b1;
    push(0, mem[exp2[7:0]]);
    tick();
    instr_enable[0] = 1'b0;
    pcin[0] = 1'b1; bus_in[0] = 16'h0300;
    tick();                                   // capture with pcin
    pcin[0] = 1'b0;
    chk("ainc_pcin_wins", pc[0], 16'h0300);
    chk("ainc_instr3", instr[0], mem[exp2[7:0]]);
    tick();
    chk("ainc_valid_end", 16'(instr_valid[0]), 16'h0000);
    tick();

    chk("sb_drain", 16'(sbq0.size() + sbq1.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
